// File: rtl/rr_rt_loge_pkg.sv
// Shared definitions for the replay-side runtime log-entry crossbar.
//   - LOGE_* : channel indices within one interface's rt_loge vector.
//   - rr_abs_dist / rr_max_dist : elaboration-time SLR distance helpers.
// Placement vectors are passed as a flat, fixed-width packed vector
// (RR_PLACE_W bits per interface, up to RR_MAX_IF interfaces). This lets the
// helpers stay ordinary package functions.
package rr_rt_loge_pkg;

    localparam int LOGE_AW = 0;
    localparam int LOGE_W  = 1;
    localparam int LOGE_AR = 2;
    localparam int LOGE_B  = 3;
    localparam int LOGE_R  = 4;

    localparam int RR_MAX_IF  = 32;
    localparam int RR_PLACE_W = 8;

    typedef logic [RR_MAX_IF*RR_PLACE_W-1:0] rr_place_t;

    function automatic int rr_abs_dist(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Largest SLR distance from any of the first n interfaces to interface t.
    function automatic int rr_max_dist(input rr_place_t place, input int n, input int t);
        int m;
        int pt;
        m  = 0;
        pt = int'(place[t*RR_PLACE_W +: RR_PLACE_W]);
        for (int s = 0; s < n; s++) begin
            if (rr_abs_dist(int'(place[s*RR_PLACE_W +: RR_PLACE_W]), pt) > m)
                m = rr_abs_dist(int'(place[s*RR_PLACE_W +: RR_PLACE_W]), pt);
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_rt_loge_delay.sv
// Fixed-length pulse delay line.
//   clk, rst     : clock, asynchronous active-high reset
//   i_din        : WIDTH pulse inputs
//   o_dout       : i_din delayed by STAGES cycles (combinational when STAGES=0)
//   o_busy_next  : some stage will hold a 1 after the next edge
// Stages have no enable, so back-to-back pulses stay distinct.
module rr_rt_loge_delay #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_busy_next
);

    generate
        if (STAGES == 0) begin : g_pass
            // No storage; clock and reset are intentionally unused here.
            logic w_unused;
            assign w_unused    = &{1'b0, clk, rst};
            assign o_dout      = i_din;
            assign o_busy_next = 1'b0;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
                end else begin
                    r_stage[0] <= i_din;
                    for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
                end
            end

            // Next-state occupancy: stage 0 takes i_din, stage k takes k-1.
            // The last stage's content moves into the counter, which reports
            // its own next state.
            always_comb begin
                o_busy_next = |i_din;
                for (int k = 0; k < STAGES - 1; k++) o_busy_next = o_busy_next | (|r_stage[k]);
            end

            assign o_dout = r_stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rr_rt_loge_evcnt.sv
// Saturating event counter for one (target, source, channel) path.
//   clk, rst    : clock, asynchronous active-high reset
//   i_inc       : arriving pulse
//   i_consume   : target retires one event (ignored while empty)
//   o_pending   : registered (count != 0), taken from the next-state value
//   o_overflow  : sticky; an arrival was dropped at saturation
//   o_nz_next   : next-state count is nonzero (feeds the idle reduction)
module rr_rt_loge_evcnt #(
    parameter int CNT_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_consume,
    output logic o_pending,
    output logic o_overflow,
    output logic o_nz_next
);

    localparam logic [CNT_WIDTH-1:0] L_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 r_pending;
    logic                 r_ovf;
    logic                 w_dec;
    logic                 w_sat;
    logic                 w_drop;

    always_comb begin
        w_dec      = i_consume && (r_cnt != '0);
        w_sat      = &r_cnt;
        // Simultaneous inc and dec cancel, even at saturation.
        w_drop     = i_inc && !w_dec && w_sat;
        w_cnt_next = r_cnt;
        if (i_inc && !w_dec && !w_sat)
            w_cnt_next = r_cnt + L_ONE;
        else if (w_dec && !i_inc)
            w_cnt_next = r_cnt - L_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_pending <= (w_cnt_next != '0);
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign o_pending  = r_pending;
    assign o_overflow = r_ovf;
    assign o_nz_next  = (w_cnt_next != '0);

endmodule

// File: rtl/rr_rt_loge_sync_xbar.sv
// Replay-side runtime log-entry crossbar.
//   clk, rst      : clock, asynchronous active-high reset
//   rt_loge_in    : [s][c] fire pulses per source interface / channel
//   consume       : [t][s][c] target t retires one event of (s, c)
//   pending       : [t][s][c] registered "counter nonzero"
//   overflow_err  : [t] sticky, some counter into t dropped an event
//   idle          : registered, no counter nonzero and no pulse in flight
// Each source->target path is delayed by its SLR distance times
// STAGES_PER_HOP (or the worst distance into t when EQUALIZE=1), then lands
// in per-channel saturating counters so no pulse is lost.
module rr_rt_loge_sync_xbar
    import rr_rt_loge_pkg::*;
#(
    parameter int LOGE_PER_INTERFACE = 5,
    parameter int NUM_INTERFACES     = 4,
    parameter logic [NUM_INTERFACES-1:0][RR_PLACE_W-1:0] PLACEMENT_VEC = '0,
    parameter int STAGES_PER_HOP     = 1,
    parameter int EQUALIZE           = 0,
    parameter int CNT_WIDTH          = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic [NUM_INTERFACES-1:0][LOGE_PER_INTERFACE-1:0]                     rt_loge_in,
    input  logic [NUM_INTERFACES-1:0][NUM_INTERFACES-1:0][LOGE_PER_INTERFACE-1:0] consume,
    output logic [NUM_INTERFACES-1:0][NUM_INTERFACES-1:0][LOGE_PER_INTERFACE-1:0] pending,
    output logic [NUM_INTERFACES-1:0]                                             overflow_err,
    output logic                                                                  idle
);

    localparam rr_place_t L_PLACE = rr_place_t'(PLACEMENT_VEC);

    logic [NUM_INTERFACES-1:0][NUM_INTERFACES-1:0][LOGE_PER_INTERFACE-1:0] w_ovf;
    logic [NUM_INTERFACES-1:0][NUM_INTERFACES-1:0][LOGE_PER_INTERFACE-1:0] w_nz_next;
    logic [NUM_INTERFACES-1:0][NUM_INTERFACES-1:0]                         w_busy_next;
    logic                                                                  r_idle;

    genvar gi, gs, gc;
    generate
        for (gi = 0; gi < NUM_INTERFACES; gi++) begin : g_tgt
            for (gs = 0; gs < NUM_INTERFACES; gs++) begin : g_src
                localparam int L_HOPS = (EQUALIZE != 0)
                    ? rr_max_dist(L_PLACE, NUM_INTERFACES, gi)
                    : rr_abs_dist(int'(PLACEMENT_VEC[gs]), int'(PLACEMENT_VEC[gi]));
                localparam int L_DLY = L_HOPS * STAGES_PER_HOP;

                logic [LOGE_PER_INTERFACE-1:0] w_arr;

                rr_rt_loge_delay #(
                    .WIDTH  (LOGE_PER_INTERFACE),
                    .STAGES (L_DLY)
                ) u_dly (
                    .clk         (clk),
                    .rst         (rst),
                    .i_din       (rt_loge_in[gs]),
                    .o_dout      (w_arr),
                    .o_busy_next (w_busy_next[gi][gs])
                );

                for (gc = 0; gc < LOGE_PER_INTERFACE; gc++) begin : g_ch
                    rr_rt_loge_evcnt #(
                        .CNT_WIDTH (CNT_WIDTH)
                    ) u_cnt (
                        .clk        (clk),
                        .rst        (rst),
                        .i_inc      (w_arr[gc]),
                        .i_consume  (consume[gi][gs][gc]),
                        .o_pending  (pending[gi][gs][gc]),
                        .o_overflow (w_ovf[gi][gs][gc]),
                        .o_nz_next  (w_nz_next[gi][gs][gc])
                    );
                end
            end

            assign overflow_err[gi] = |w_ovf[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_idle <= 1'b1;
        else     r_idle <= ~((|w_nz_next) | (|w_busy_next));
    end

    assign idle = r_idle;

endmodule

// File: tb/tb_rr_rt_loge_sync_xbar.sv
module tb_rr_rt_loge_sync_xbar;
    import rr_rt_loge_pkg::*;

    localparam int N = 4;
    localparam int L = 5;
    // P = {0,0,1,2} for interfaces 0..3
    localparam logic [N-1:0][7:0] P = {8'd2, 8'd1, 8'd0, 8'd0};

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0][L-1:0]        rt_loge_in;
    logic [N-1:0][N-1:0][L-1:0] consume;
    logic [N-1:0][N-1:0][L-1:0] pend0, pend1;
    logic [N-1:0]               ovf0, ovf1;
    logic                       idle0, idle1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_rt_loge_sync_xbar #(
        .LOGE_PER_INTERFACE (L), .NUM_INTERFACES (N), .PLACEMENT_VEC (P),
        .STAGES_PER_HOP (1), .EQUALIZE (0), .CNT_WIDTH (4)
    ) u_eq0 (
        .clk (clk), .rst (rst), .rt_loge_in (rt_loge_in), .consume (consume),
        .pending (pend0), .overflow_err (ovf0), .idle (idle0)
    );

    rr_rt_loge_sync_xbar #(
        .LOGE_PER_INTERFACE (L), .NUM_INTERFACES (N), .PLACEMENT_VEC (P),
        .STAGES_PER_HOP (1), .EQUALIZE (1), .CNT_WIDTH (4)
    ) u_eq1 (
        .clk (clk), .rst (rst), .rt_loge_in (rt_loge_in), .consume (consume),
        .pending (pend1), .overflow_err (ovf1), .idle (idle1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rt_loge_in = '0;
        consume    = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        rt_loge_in = '0;
        consume    = '0;
        repeat (2) tick();
        chk("rst_pending", {31'b0, |pend0}, 0);
        chk("rst_ovf", {28'b0, ovf0}, 0);
        chk("rst_idle", {31'b0, idle0}, 1);
        rst = 1'b0;
        tick();

        // 1: per-path delays, source 0 channel W
        rt_loge_in[0][LOGE_W] = 1'b1;
        tick();                                   // cycle 1
        rt_loge_in = '0;
        chk("t1_p00_c1", {31'b0, pend0[0][0][LOGE_W]}, 1);
        chk("t1_p10_c1", {31'b0, pend0[1][0][LOGE_W]}, 1);
        chk("t1_p20_c1", {31'b0, pend0[2][0][LOGE_W]}, 0);
        chk("t1_idle_c1", {31'b0, idle0}, 0);
        tick();                                   // cycle 2
        chk("t1_p20_c2", {31'b0, pend0[2][0][LOGE_W]}, 1);
        chk("t1_p30_c2", {31'b0, pend0[3][0][LOGE_W]}, 0);
        tick();                                   // cycle 3
        chk("t1_p30_c3", {31'b0, pend0[3][0][LOGE_W]}, 1);
        do_reset();

        // 2: equalised arrival into target 1
        rt_loge_in[0][LOGE_AW] = 1'b1;
        rt_loge_in[3][LOGE_AW] = 1'b1;
        tick();                                   // cycle 1
        rt_loge_in = '0;
        chk("t2_eq0_p10_c1", {31'b0, pend0[1][0][LOGE_AW]}, 1);
        chk("t2_p10_c1", {31'b0, pend1[1][0][LOGE_AW]}, 0);
        tick();                                   // cycle 2
        chk("t2_p10_c2", {31'b0, pend1[1][0][LOGE_AW]}, 0);
        chk("t2_p13_c2", {31'b0, pend1[1][3][LOGE_AW]}, 0);
        tick();                                   // cycle 3
        chk("t2_p10_c3", {31'b0, pend1[1][0][LOGE_AW]}, 1);
        chk("t2_p13_c3", {31'b0, pend1[1][3][LOGE_AW]}, 1);
        do_reset();

        // 3: saturation on D=0 path (t0, s0, AR)
        for (int i = 0; i < 16; i++) begin
            rt_loge_in[0][LOGE_AR] = 1'b1;
            tick();
            if (i == 14) chk("t3_no_ovf_at15", {28'b0, ovf0}, 0);
        end
        rt_loge_in = '0;
        chk("t3_ovf_set", {31'b0, ovf0[0]}, 1);
        for (int i = 0; i < 15; i++) begin
            consume[0][0][LOGE_AR] = 1'b1;
            tick();
            if (i == 13) chk("t3_pend_after14", {31'b0, pend0[0][0][LOGE_AR]}, 1);
        end
        consume = '0;
        chk("t3_pend_after15", {31'b0, pend0[0][0][LOGE_AR]}, 0);
        chk("t3_ovf_sticky", {31'b0, ovf0[0]}, 1);
        do_reset();

        // 4: inc+dec at saturation, consume on empty (t1, s1, B)
        for (int i = 0; i < 15; i++) begin
            rt_loge_in[1][LOGE_B] = 1'b1;
            tick();
        end
        consume[1][1][LOGE_B] = 1'b1;             // arrival and consume together
        tick();
        rt_loge_in = '0;
        chk("t4_no_ovf", {31'b0, ovf0[1]}, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 13) chk("t4_pend_after14", {31'b0, pend0[1][1][LOGE_B]}, 1);
        end
        consume = '0;
        chk("t4_pend_after15", {31'b0, pend0[1][1][LOGE_B]}, 0);
        consume[1][1][LOGE_B] = 1'b1;             // consume while empty
        tick();
        consume = '0;
        chk("t4_empty_consume", {31'b0, pend0[1][1][LOGE_B]}, 0);
        rt_loge_in[1][LOGE_B] = 1'b1;
        tick();
        rt_loge_in = '0;
        chk("t4_one_event", {31'b0, pend0[1][1][LOGE_B]}, 1);
        consume[1][1][LOGE_B] = 1'b1;
        tick();
        consume = '0;
        chk("t4_one_consumed", {31'b0, pend0[1][1][LOGE_B]}, 0);
        chk("t4_ovf_final", {31'b0, ovf0[1]}, 0);
        do_reset();

        // 5: reset with count 3 and two pulses in flight on D=2 (t3, s1, R)
        for (int i = 0; i < 3; i++) begin
            rt_loge_in[1][LOGE_R] = 1'b1;
            tick();
        end
        rt_loge_in = '0;
        repeat (3) tick();
        chk("t5_pend_cnt3", {31'b0, pend0[3][1][LOGE_R]}, 1);
        rt_loge_in[1][LOGE_R] = 1'b1;
        repeat (2) tick();
        rt_loge_in = '0;
        rst = 1'b1;
        tick();
        chk("t5_rst_pending", {31'b0, |pend0}, 0);
        chk("t5_rst_idle", {31'b0, idle0}, 1);
        chk("t5_rst_ovf", {28'b0, ovf0}, 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("t5_no_late", {31'b0, pend0[3][1][LOGE_R]}, 0);
        chk("t5_idle_after", {31'b0, idle0}, 1);

        // 6: idle tracking for a single pulse (s0, AW)
        rt_loge_in[0][LOGE_AW] = 1'b1;
        tick();                                   // cycle 1
        rt_loge_in = '0;
        chk("t6_idle_drop", {31'b0, idle0}, 0);
        tick();                                   // cycle 2
        chk("t6_p20_c2", {31'b0, pend0[2][0][LOGE_AW]}, 1);
        consume[0][0][LOGE_AW] = 1'b1;
        consume[1][0][LOGE_AW] = 1'b1;
        consume[2][0][LOGE_AW] = 1'b1;
        tick();                                   // cycle 3
        consume = '0;
        chk("t6_idle_c3", {31'b0, idle0}, 0);
        chk("t6_p30_c3", {31'b0, pend0[3][0][LOGE_AW]}, 1);
        consume[3][0][LOGE_AW] = 1'b1;
        tick();                                   // cycle 4
        consume = '0;
        chk("t6_idle_back", {31'b0, idle0}, 1);
        chk("t6_all_clear", {31'b0, |pend0}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_rt_loge_sync_xbar.md
# rr_rt_loge_sync_xbar

Replay-side runtime log-entry crossbar. Distributes each interface's per-channel handshake-fire pulses (`rt_loge`) to every interface. Each source→target path gets an SLR-distance-derived pipeline delay, with an optional per-target equalisation mode. Unlike a plain wire/pipe crossbar, every (target, source, channel) path ends in a saturating event counter with a consume handshake, so no pulse is lost when a replay engine cannot act on it in the arrival cycle.

## Interface
Parameters:
- `LOGE_PER_INTERFACE`, 5, channels per interface (AW, W, AR, B, R).
- `NUM_INTERFACES`, 4, number of AXI/AXI-Lite interfaces.
- `PLACEMENT_VEC[NUM_INTERFACES-1:0]`, all 0, SLR index per interface.
- `STAGES_PER_HOP`, 1, pipeline stages per unit of SLR distance.
- `EQUALIZE`, 0: 0 means per-path delay; 1 means all sources into target t share the max delay for t.
- `CNT_WIDTH`, 4, width of each event counter.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rt_loge_in[NUM][LOGE]` in: fire pulses per source interface/channel.
- `consume[NUM][NUM][LOGE]` in, indexed [t][s][c]: target t retires one event of (s, c).
- `pending[NUM][NUM][LOGE]` out, [t][s][c]: counter nonzero; registered.
- `overflow_err[NUM]` out: sticky per target; a saturated counter dropped an event.
- `idle` out 1: all counters zero and all delay stages empty; registered.

## Operation
- Path delay: D(s,t) = |P[s]−P[t]|·STAGES_PER_HOP.
  - EQUALIZE=1: D(s,t) = max over s' of D(s',t).
  - D=0: the input feeds the counter increment combinationally.
  - D>0: D register stages, no enable, one pulse per stage.
- Counter update per (t,s,c):
  - inc = arriving pulse.
  - dec = `consume` AND cnt≠0.
  - cnt_next = cnt + inc − dec.
- Saturation: cnt = 2^CNT_WIDTH−1 with inc and no dec leaves cnt unchanged and sets `overflow_err[t]`. The error clears only on `rst`.
- inc and dec in the same cycle leave cnt unchanged, including at saturation (no error).
- `consume` while cnt=0 is ignored, with no error.
- `pending` = (cnt≠0), registered from the next-state value. It reflects arrivals and consumes one cycle after they happen.
- `idle` = no counter nonzero and no delay stage holding a 1, evaluated on next state, registered.

## Timing
- Reset values: all stages 0, all counters 0, `pending` all 0, `overflow_err` 0, `idle` 1.
- Latency from `rt_loge_in` to `pending` is D(s,t)+1 cycles.
- Latency from `consume` to `pending` deassert is 1 cycle when cnt was 1.
- Throughput: one event per path per cycle. Back-to-back pulses stay distinct through the stages.
- `rst` mid-operation discards in-flight pulses and counts immediately, with no flush.
- Order across sources is not preserved unless EQUALIZE=1. In that mode, pulses fired in the same cycle on any sources reach target t in the same cycle.

## Structure
- Shared package `rr_rt_loge_pkg` holds:
  - `LOGE_AW`, `LOGE_W`, `LOGE_AR`, `LOGE_B`, `LOGE_R` indices;
  - `rr_abs_dist` and `rr_max_dist` elaboration functions.
- Sub-module `rr_rt_loge_delay`: WIDTH/STAGES parametrised, async active-high reset, pass-through when STAGES=0.
- Sub-module `rr_rt_loge_evcnt`: one saturating counter per path, with `pending` and overflow outputs.
- Top level: generate loops over t, s; OR-reduce overflow per t; AND-reduce for `idle`.

## Test plan
Common setup: P={0,0,1,2}, STAGES_PER_HOP=1, CNT_WIDTH=4.
1. EQUALIZE=0. Pulse `rt_loge_in[0][LOGE_W]` at cycle 0.
   - `pending[0][0][W]` and `pending[1][0][W]` high at cycle 1.
   - `pending[2][0][W]` high at cycle 2.
   - `pending[3][0][W]` high at cycle 3.
2. EQUALIZE=1. Pulse sources 0 and 3 on AW at cycle 0.
   - `pending[1][0][AW]` and `pending[1][3][AW]` both rise at cycle 3.
3. Pulse every cycle on 16 consecutive cycles into a D=0 path, no consume.
   - Counter reaches 15 at the 15th pulse.
   - 16th pulse sets `overflow_err[t]`, which stays set.
   - Then 15 consumes drop `pending` at the following cycle.
4. Counter at 15: arrival and consume in the same cycle.
   - Count stays 15, `overflow_err` stays 0.
   - `consume` on an empty counter: no change.
5. Assert `rst` with 2 pulses in flight on a D=2 path and count 3.
   - Next edge: `pending` 0, `idle` 1, `overflow_err` 0.
   - No late arrivals after release.
6. Fire a single pulse.
   - `idle` drops the cycle after the fire.
   - `idle` returns 1 the cycle after the last path's `pending` is consumed.
